// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcodes, datapath select encodings and per-state control decode for mc_control.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
   localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALURESULT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       adr_src;
      logic       fetch;
      logic       pc_update;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       illegal;
   } ctl_t;

   // fetch marks the state whose IRWrite/PCUpdate follow mem_ready
   function automatic ctl_t ctl_of(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.src_a = SRCA_PC; c.src_b = SRCB_4; c.alu_op = ALU_ADD; c.result_src = RES_ALURESULT; end
         DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
         MEMADR:   begin c.src_a = SRCA_RD1; c.src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
         MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
         MEMWB:    begin c.result_src = RES_RDATA; c.reg_write = 1'b1; end
         MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; c.result_src = RES_ALUOUT; end
         EXECUTER: begin c.src_a = SRCA_RD1; c.src_b = SRCB_RD2; c.alu_op = ALU_FUNCT; end
         EXECUTEI: begin c.src_a = SRCA_RD1; c.src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
         ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
         JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_4; c.alu_op = ALU_ADD; c.result_src = RES_ALUOUT; c.pc_update = 1'b1; end
         BEQ:      begin c.src_a = SRCA_RD1; c.src_b = SRCB_RD2; c.alu_op = ALU_SUB; c.result_src = RES_ALUOUT; c.branch = 1'b1; end
         default:  c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control.sv
// mc_control: multicycle RISC-V main control FSM with registered control outputs and retired-instruction counter.
module mc_control
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opCode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCUpdate,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             Branch,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ResultSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t state, nxt;
   ctl_t   ctl;
   logic   retire;

   always_comb begin
      nxt = state;
      case (state)
         FETCH:    nxt = mem_ready ? DECODE : FETCH;
         DECODE:   nxt = (opCode == OP_LW || opCode == OP_SW) ? MEMADR :
                         opCode == OP_R   ? EXECUTER :
                         opCode == OP_I   ? EXECUTEI :
                         opCode == OP_JAL ? JAL :
                         opCode == OP_BEQ ? BEQ : TRAP;
         MEMADR:   nxt = opCode == OP_LW ? MEMREAD : MEMWRITE;
         MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
         MEMWB, ALUWB, BEQ:      nxt = FETCH;
         EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
         default:  nxt = TRAP;
      endcase
   end

   assign retire = state == MEMWB || state == ALUWB || state == BEQ || (state == MEMWRITE && mem_ready);

   // outputs are decoded from the next state so they are registered alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         ctl     <= ctl_of(FETCH);
         instret <= '0;
      end else begin
         state   <= nxt;
         ctl     <= ctl_of(nxt);
         instret <= instret + CNT_W'(retire);
      end
   end

   assign mem_req   = ctl.mem_req;
   assign AdrSrc    = ctl.adr_src;
   assign IRWrite   = ctl.fetch & mem_ready;
   assign PCUpdate  = ctl.pc_update | (ctl.fetch & mem_ready);
   assign RegWrite  = ctl.reg_write;
   assign MemWrite  = ctl.mem_write;
   assign Branch    = ctl.branch;
   assign ALUSrcA   = ctl.src_a;
   assign ALUSrcB   = ctl.src_b;
   assign ALUOp     = ctl.alu_op;
   assign ResultSrc = ctl.result_src;
   assign illegal   = ctl.illegal;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: instruction-level reference model feeding a per-cycle scoreboard for mc_control.
module tb_mc_control;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [6:0]   opCode = '0;
   logic         mem_ready = 1'b0;
   logic         mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, illegal;
   logic [1:0]   ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic [W-1:0] instret;

   mc_control #(.CNT_W(W)) dut (
      .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
      .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   // {mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal}
   function automatic logic [15:0] v(input bit mq, ad, ir, pc, rw, mw, br, input logic [1:0] a, b, op, rs, input bit il);
      return {mq, ad, ir, pc, rw, mw, br, a, b, op, rs, il};
   endfunction

   localparam logic [15:0] IRPC = 16'h3000;
   logic [15:0] F, D, MA, MR, MWB, MW, ER, EI, AW, J, B, T;

   logic [15:0]  expq[$];
   logic [W-1:0] cntq[$];
   logic [W-1:0] cnt;
   int tests = 0, fails = 0;

   task automatic cyc(input logic [15:0] e, input bit mr, input bit rs = 1'b0);
      @(negedge clk);
      reset = rs;
      mem_ready = mr;
      expq.push_back(e);
      cntq.push_back(cnt);
   endtask

   task automatic waitstep(input logic [15:0] e, input bit fetch, input int lows);
      int n;
      n = lows < 0 ? int'($urandom_range(0, 3)) : lows;
      repeat (n) cyc(e, 1'b0);
      cyc(fetch ? (e | IRPC) : e, 1'b1);
   endtask

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run(input logic [6:0] op, input int lows);
      opCode = op;
      waitstep(F, 1'b1, lows);
      cyc(D, rnd());
      case (op)
         7'b0000011: begin cyc(MA, rnd()); waitstep(MR, 1'b0, lows); cyc(MWB, rnd()); cnt = cnt + 1'b1; end
         7'b0100011: begin cyc(MA, rnd()); waitstep(MW, 1'b0, lows); cnt = cnt + 1'b1; end
         7'b0110011: begin cyc(ER, rnd()); cyc(AW, rnd()); cnt = cnt + 1'b1; end
         7'b0010011: begin cyc(EI, rnd()); cyc(AW, rnd()); cnt = cnt + 1'b1; end
         7'b1101111: begin cyc(J, rnd()); cyc(AW, rnd()); cnt = cnt + 1'b1; end
         7'b1100011: begin cyc(B, rnd()); cnt = cnt + 1'b1; end
         default:    repeat (10) cyc(T, rnd());
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            logic [15:0]  e, a;
            logic [W-1:0] c;
            e = expq.pop_front();
            c = cntq.pop_front();
            a = {mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL ctl t=%0t opCode=%b got=%b want=%b", $time, opCode, a, e);
            end
            tests++;
            if (instret !== c) begin
               fails++;
               $display("FAIL instret t=%0t got=%0d want=%0d", $time, instret, c);
            end
         end
      end
   end

   initial begin
      logic [6:0] ops[6];
      F   = v(1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
      D   = v(0,0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
      MA  = v(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
      MR  = v(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      MWB = v(0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 0);
      MW  = v(1,1,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      ER  = v(0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
      EI  = v(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b10, 2'b00, 0);
      AW  = v(0,0,0,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      J   = v(0,0,0,1,0,0,0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
      B   = v(0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b01, 2'b00, 0);
      T   = v(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
      cnt = '0;
      repeat (2) @(negedge clk);
      run(7'b0000011, 0);
      run(7'b0100011, 3);
      run(7'b1101111, 0);
      run(7'b1100011, 1);
      run(7'b1111111, 0);
      cyc(T, 1'b1, 1'b1);
      cnt = '0;
      repeat (16) run(7'b0110011, -1);
      run(7'b0010011, 2);
      opCode = 7'b0000011;
      waitstep(F, 1'b1, 0);
      cyc(D, 1'b1);
      cyc(MA, 1'b1);
      cyc(MR, 1'b0, 1'b1);
      cnt = '0;
      repeat (40) run(ops[$urandom_range(0, 5)], -1);
      run(7'b0000000, -1);
      cyc(T, 1'b0, 1'b1);
      cnt = '0;
      run(7'b0110011, 0);
      repeat (3) @(negedge clk);
      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL drain got=%0d want=0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
